// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : alu_pkg
// Brief   : Opcodes, MUL FSM state encoding and flag bundle for the ALU.
// Revision: 1.0
// ============================================================================
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_SLTU = 4'b0110;
    localparam logic [3:0] OP_SLL  = 4'b0111;
    localparam logic [3:0] OP_SRL  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;
    localparam logic [3:0] OP_MUL  = 4'b1010;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_MUL  = 1'b1;

    typedef struct packed {
        logic n;
        logic z;
        logic v;
        logic c;
    } alu_flags_t;

endpackage
`default_nettype wire

// File: rtl/alu_pipe_if.sv
`default_nettype none
// ============================================================================
// Module  : alu_pipe_if
// Brief   : Issue-side and writeback-side handshake bundle of the ALU.
// Revision: 1.0
// ============================================================================
interface alu_pipe_if #(
    parameter int XLEN = 32,
    parameter int TAGW = 4
);
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      in_op;
    logic [XLEN-1:0] in_a;
    logic [XLEN-1:0] in_b;
    logic [TAGW-1:0] in_tag;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_res;
    logic            out_n;
    logic            out_z;
    logic            out_v;
    logic            out_c;
    logic [TAGW-1:0] out_tag;
    logic            out_illegal;

    modport master (
        output in_valid, in_op, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_res, out_n, out_z, out_v, out_c,
               out_tag, out_illegal
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_res, out_n, out_z, out_v, out_c,
               out_tag, out_illegal
    );
endinterface
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
// Module  : alu_core
// Brief   : Combinational single-cycle datapath: result, N/Z/V/C, illegal.
// Revision: 1.0
// ============================================================================
module alu_core
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  wire logic [3:0]      i_op,
    input  wire logic [XLEN-1:0] i_a,
    input  wire logic [XLEN-1:0] i_b,
    output logic      [XLEN-1:0] o_res,
    output alu_flags_t           o_flags,
    output logic                 o_illegal
);
    localparam int SHW = $clog2(XLEN);

    logic            w_sub;
    logic [XLEN-1:0] w_bx;
    logic [XLEN:0]   w_sum;
    logic            w_ovf;
    logic [SHW-1:0]  w_shamt;

    // SLT reuses the subtractor so the signed compare is sum sign XOR overflow
    assign w_sub   = (i_op == OP_SUB) || (i_op == OP_SLT);
    assign w_bx    = w_sub ? ~i_b : i_b;
    assign w_sum   = {1'b0, i_a} + {1'b0, w_bx} + {{XLEN{1'b0}}, w_sub};
    assign w_ovf   = (i_a[XLEN-1] == w_bx[XLEN-1]) && (w_sum[XLEN-1] != i_a[XLEN-1]);
    assign w_shamt = i_b[SHW-1:0];

    always_comb begin
        o_res     = '0;
        o_illegal = 1'b0;
        o_flags   = '0;
        case (i_op)
            OP_ADD, OP_SUB: begin
                o_res     = w_sum[XLEN-1:0];
                o_flags.v = w_ovf;
                o_flags.c = w_sum[XLEN];
            end
            OP_AND:  o_res = i_a & i_b;
            OP_OR:   o_res = i_a | i_b;
            OP_XOR:  o_res = i_a ^ i_b;
            OP_SLT:  o_res = {{(XLEN-1){1'b0}}, w_sum[XLEN-1] ^ w_ovf};
            OP_SLTU: o_res = {{(XLEN-1){1'b0}}, (i_a < i_b)};
            OP_SLL:  o_res = i_a << w_shamt;
            OP_SRL:  o_res = i_a >> w_shamt;
            OP_SRA:  o_res = $unsigned($signed(i_a) >>> w_shamt);
            default: o_illegal = 1'b1;
        endcase
        o_flags.n = o_res[XLEN-1];
        o_flags.z = (o_res == '0);
    end
endmodule
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
// Module  : alu_pipe
// Brief   : Handshaked ALU with output register, iterative MUL and flush.
// Revision: 1.0
// ============================================================================
module alu_pipe
    import alu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int TAGW   = 4,
    parameter int MUL_EN = 1
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    input  wire logic   flush,
    output logic        busy,
    alu_pipe_if.slave   bus
);
    localparam int CW = $clog2(XLEN) + 1;

    logic [0:0]      r_state;
    logic [CW-1:0]   r_cnt;
    logic [XLEN-1:0] r_acc;
    logic [XLEN-1:0] r_mcand;
    logic [XLEN-1:0] r_mplier;
    logic [TAGW-1:0] r_tag_pend;
    logic            r_valid;
    logic [XLEN-1:0] r_res;
    alu_flags_t      r_flags;
    logic [TAGW-1:0] r_tag;
    logic            r_illegal;

    logic [XLEN-1:0] w_core_res;
    alu_flags_t      w_core_flags;
    logic            w_core_ill;
    logic            w_accept;
    logic            w_retire;
    logic            w_is_mul;
    logic [XLEN-1:0] w_acc_next;

    alu_core #(.XLEN(XLEN)) u_core (
        .i_op      (bus.in_op),
        .i_a       (bus.in_a),
        .i_b       (bus.in_b),
        .o_res     (w_core_res),
        .o_flags   (w_core_flags),
        .o_illegal (w_core_ill)
    );

    assign bus.in_ready = (r_state == ST_IDLE) && (!r_valid || bus.out_ready) && !flush;
    assign w_accept     = bus.in_valid && bus.in_ready;
    assign w_retire     = r_valid && bus.out_ready;
    // With MUL disabled the opcode falls through to the core, which flags it illegal
    assign w_is_mul     = (MUL_EN != 0) && (bus.in_op == OP_MUL);
    assign w_acc_next   = r_acc + (r_mplier[0] ? r_mcand : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_tag_pend <= '0;
            r_valid    <= 1'b0;
            r_res      <= '0;
            r_flags    <= '0;
            r_tag      <= '0;
            r_illegal  <= 1'b0;
        end else if (flush) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
        end else begin
            if (w_retire) begin
                r_valid <= 1'b0;
            end
            if (w_accept) begin
                if (w_is_mul) begin
                    r_state    <= ST_MUL;
                    r_cnt      <= CW'(XLEN);
                    r_acc      <= '0;
                    r_mcand    <= bus.in_a;
                    r_mplier   <= bus.in_b;
                    r_tag_pend <= bus.in_tag;
                end else begin
                    r_res     <= w_core_res;
                    r_flags   <= w_core_flags;
                    r_illegal <= w_core_ill;
                    r_tag     <= bus.in_tag;
                    r_valid   <= 1'b1;
                end
            end
            // One shift-add step per edge; the last step publishes the product
            if (r_state == ST_MUL) begin
                r_acc    <= w_acc_next;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt - CW'(1);
                if (r_cnt == CW'(1)) begin
                    r_res     <= w_acc_next;
                    r_flags   <= '{n: w_acc_next[XLEN-1], z: (w_acc_next == '0), v: 1'b0, c: 1'b0};
                    r_illegal <= 1'b0;
                    r_tag     <= r_tag_pend;
                    r_valid   <= 1'b1;
                    r_state   <= ST_IDLE;
                end
            end
        end
    end

    assign busy            = (r_state == ST_MUL);
    assign bus.out_valid   = r_valid;
    assign bus.out_res     = r_res;
    assign bus.out_n       = r_flags.n;
    assign bus.out_z       = r_flags.z;
    assign bus.out_v       = r_flags.v;
    assign bus.out_c       = r_flags.c;
    assign bus.out_tag     = r_tag;
    assign bus.out_illegal = r_illegal;
endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_pipe
// Brief   : Scoreboard bench for alu_pipe with a plain-arithmetic reference.
// Revision: 1.0
// ============================================================================
module tb_alu_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic flush = 1'b0;
    logic busy;
    int   total = 0;
    int   bad = 0;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  nzvc;
        logic [3:0]  tag;
        logic        ill;
    } exp_t;

    exp_t sb[$];

    alu_pipe_if #(.XLEN(32), .TAGW(4)) bus ();

    alu_pipe #(.XLEN(32), .TAGW(4), .MUL_EN(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .busy  (busy),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [3:0] tag);
        exp_t e;
        longint sa = longint'($signed(a));
        longint sb_ = longint'($signed(b));
        longint unsigned ua = a;
        longint unsigned ub = b;
        longint sr;
        int sh = int'(b % 32);
        logic v = 1'b0, c = 1'b0;
        e.ill = 1'b0;
        e.tag = tag;
        case (op)
            4'd0: begin e.res = a + b; c = (ua + ub) > 64'hFFFF_FFFF; sr = sa + sb_;
                        v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648); end
            4'd1: begin e.res = a - b; c = (ua >= ub); sr = sa - sb_;
                        v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648); end
            4'd2: e.res = a & b;
            4'd3: e.res = a | b;
            4'd4: e.res = a ^ b;
            4'd5: e.res = (sa < sb_) ? 32'd1 : 32'd0;
            4'd6: e.res = (ua < ub) ? 32'd1 : 32'd0;
            4'd7: e.res = a << sh;
            4'd8: e.res = a >> sh;
            4'd9: e.res = $unsigned($signed(a) >>> sh);
            4'd10: e.res = 32'(ua * ub);
            default: begin e.res = 32'd0; e.ill = 1'b1; end
        endcase
        e.nzvc = {e.res[31], (e.res == 32'd0), v, c};
        return e;
    endfunction

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_result", {32'd0, bus.out_res}, 64'hDEAD);
                end else begin
                    e = sb.pop_front();
                    chk("sb_res", 64'(bus.out_res), 64'(e.res));
                    chk("sb_flags", 64'({bus.out_n, bus.out_z, bus.out_v, bus.out_c}), 64'(e.nzvc));
                    chk("sb_tag", 64'(bus.out_tag), 64'(e.tag));
                    chk("sb_illegal", 64'(bus.out_illegal), 64'(e.ill));
                end
            end
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the accept edge
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] tag, input bit rnd_ready, output int waited);
        bus.in_op = op; bus.in_a = a; bus.in_b = b; bus.in_tag = tag;
        bus.in_valid = 1'b1;
        waited = 0;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            waited++;
            if (waited > 200) begin
                chk("issue_timeout", 64'(waited), 64'd0);
                bus.in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
            if (rnd_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        sb.push_back(model(op, a, b, tag));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic issue_expect(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [3:0] tag, input logic [31:0] xres, input logic [3:0] xf,
                                input string name);
        int w;
        issue(op, a, b, tag, 1'b0, w);
        chk({name, "_valid"}, 64'(bus.out_valid), 64'd1);
        chk({name, "_res"}, 64'(bus.out_res), 64'(xres));
        chk({name, "_flags"}, 64'({bus.out_n, bus.out_z, bus.out_v, bus.out_c}), 64'(xf));
    endtask

    initial begin
        int w, k, hit;
        logic [31:0] r1;
        logic [31:0] ops_a[6];
        bus.in_valid = 1'b0; bus.in_op = '0; bus.in_a = '0; bus.in_b = '0; bus.in_tag = '0;
        bus.out_ready = 1'b0;
        fork monitor(); join_none

        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_res", 64'(bus.out_res), 64'd0);
        chk("rst_flags_tag_ill", 64'({bus.out_n, bus.out_z, bus.out_v, bus.out_c, bus.out_tag, bus.out_illegal}), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

        bus.out_ready = 1'b1;
        issue_expect(4'd0, 32'h7FFF_FFFF, 32'h1, 4'h1, 32'h8000_0000, 4'b1010, "add_ovf");
        issue_expect(4'd1, 32'd5, 32'd5, 4'h2, 32'h0, 4'b0101, "sub_zero");
        issue_expect(4'd1, 32'd0, 32'd1, 4'h3, 32'hFFFF_FFFF, 4'b1000, "sub_borrow");
        issue_expect(4'd5, 32'hFFFF_FFFF, 32'd1, 4'h4, 32'd1, 4'b0000, "slt");
        issue_expect(4'd6, 32'hFFFF_FFFF, 32'd1, 4'h5, 32'd0, 4'b0100, "sltu");
        issue_expect(4'd9, 32'h8000_0000, 32'h21, 4'h6, 32'hC000_0000, 4'b1000, "sra");
        issue_expect(4'd15, 32'h1234, 32'h5678, 4'h7, 32'd0, 4'b0100, "illegal");
        chk("illegal_flag", 64'(bus.out_illegal), 64'd1);

        // MUL latency: result must appear on exactly the 32nd edge after accept
        issue(4'd10, 32'h0000_FFFF, 32'h0001_0001, 4'h8, 1'b0, w);
        hit = 0;
        k = 0;
        for (int i = 1; i <= 40; i++) begin
            if (!busy || bus.in_ready) hit++;
            @(posedge clk); #1;
            if (bus.out_valid) begin k = i; break; end
        end
        chk("mul_busy_ready", 64'(hit), 64'd0);
        chk("mul_latency", 64'(k), 64'd32);
        chk("mul_res", 64'(bus.out_res), 64'hFFFF_FFFF);
        chk("mul_busy_after", 64'(busy), 64'd0);
        @(posedge clk); #1;

        // Backpressure: hold first result while a second op waits
        bus.out_ready = 1'b0;
        issue(4'd0, 32'd100, 32'd23, 4'hA, 1'b0, w);
        r1 = 32'd123;
        bus.in_op = 4'd0; bus.in_a = 32'd1; bus.in_b = 32'd2; bus.in_tag = 4'hB;
        bus.in_valid = 1'b1;
        hit = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.in_ready || !bus.out_valid || bus.out_res !== r1 || bus.out_tag !== 4'hA) hit++;
        end
        chk("bp_hold", 64'(hit), 64'd0);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        issue(4'd0, 32'd1, 32'd2, 4'hB, 1'b0, w);
        chk("bp_stream2", 64'(w), 64'd0);
        issue(4'd0, 32'd3, 32'd4, 4'hC, 1'b0, w);
        chk("bp_stream3", 64'(w), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("bp_drained", 64'(sb.size()), 64'd0);

        // Flush on MUL step 10, with a competing request that must be ignored
        issue(4'd10, 32'd7, 32'd9, 4'hD, 1'b0, w);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        bus.in_op = 4'd0; bus.in_a = 32'd1; bus.in_b = 32'd1; bus.in_tag = 4'hE;
        bus.in_valid = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush_busy", 64'(busy), 64'd0);
        chk("flush_valid", 64'(bus.out_valid), 64'd0);
        chk("flush_sb", 64'(sb.size()), 64'd1);
        sb.delete();
        hit = 0;
        repeat (40) begin @(posedge clk); #1; if (bus.out_valid) hit++; end
        chk("flush_no_result", 64'(hit), 64'd0);

        // Flush drops a held result
        bus.out_ready = 1'b0;
        issue(4'd0, 32'd3, 32'd4, 4'h9, 1'b0, w);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_held", 64'(bus.out_valid), 64'd0);
        sb.delete();
        bus.out_ready = 1'b1;

        // Asynchronous reset in the middle of a MUL
        issue(4'd10, 32'd3, 32'd5, 4'h6, 1'b0, w);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_valid_busy", 64'({bus.out_valid, busy}), 64'd0);
        chk("arst_res", 64'(bus.out_res), 64'd0);
        chk("arst_flags_tag_ill", 64'({bus.out_n, bus.out_z, bus.out_v, bus.out_c, bus.out_tag, bus.out_illegal}), 64'd0);
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        hit = 0;
        repeat (40) begin @(posedge clk); #1; if (bus.out_valid) hit++; end
        chk("arst_no_result", 64'(hit), 64'd0);
        chk("arst_in_ready", 64'(bus.in_ready), 64'd1);

        // Randomized traffic with random backpressure
        ops_a[0] = 32'h0; ops_a[1] = 32'hFFFF_FFFF; ops_a[2] = 32'h8000_0000;
        ops_a[3] = 32'h7FFF_FFFF; ops_a[4] = 32'h1; ops_a[5] = 32'h5555_AAAA;
        for (int n = 0; n < 250; n++) begin
            logic [31:0] ra, rb;
            ra = ($urandom_range(0, 3) == 0) ? ops_a[$urandom_range(0, 5)] : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? ops_a[$urandom_range(0, 5)] : $urandom;
            bus.out_ready = ($urandom_range(0, 3) != 0);
            issue(4'($urandom_range(0, 15)), ra, rb, 4'($urandom), 1'b1, w);
        end
        bus.out_ready = 1'b1;
        k = 0;
        while ((sb.size() != 0 || busy) && k < 100) begin @(posedge clk); #1; k++; end
        @(posedge clk); #1;
        chk("final_drain", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
